if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
Parametrised IF/ID boundary stage that replaces the single stall-able IF/ID register with a DEPTH-entry in-order queue.
- Fetch and decode are coupled by a valid/ready handshake, so fetch keeps running while decode back-pressures.
- Carries PC, instruction and a branch-predicted-taken bit.
- Supports pipeline flush and substitutes the canonical NOP for empty instructions.
- Sits between the fetch unit and the decode stage.

Parameters:
XLEN, 32, PC width in bits
ILEN, 32, instruction width in bits
DEPTH, 2, queue entries (1..8; need not be a power of 2)
NOP_INSTR, 32'h00000013, instruction presented when the queue is empty and substituted for all-zero instructions (width ILEN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush; discards all queued entries
in_valid  in  1  fetch presents an entry
in_ready  out  1  queue can accept; high when count < DEPTH
in_instr  in  ILEN  fetched instruction
in_pc  in  XLEN  PC of fetched instruction
in_pred_taken  in  1  branch predictor taken flag
out_valid  out  1  head entry present; high when count > 0
out_ready  in  1  decode consumes head this cycle
out_instr  out  ILEN  head instruction, or NOP_INSTR when empty
out_pc  out  XLEN  head PC, or 0 when empty
out_pred_taken  out  1  head predicted-taken flag, or 0 when empty
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; all storage entries clear to {NOP_INSTR, 0, 0}.
  - Outputs: out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pred_taken=0, in_ready=1, count=0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Push: occurs on an edge where in_valid & in_ready & !flush.
  - Writes the entry at wr_ptr, then advances wr_ptr with wrap from DEPTH-1 to 0.
  - If in_instr == 0, the stored instruction is NOP_INSTR; PC and pred_taken are stored unchanged.
- Pop: occurs on an edge where out_valid & out_ready & !flush.
  - Advances rd_ptr with wrap from DEPTH-1 to 0.
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop.
- Latency:
  - An entry pushed into an empty queue appears on out_* in the next cycle.
  - No combinational path from in_* to out_*.
- Output path:
  - out_* is the combinational read of the entry at rd_ptr, muxed to the empty values when count == 0.
  - Outputs never show stale storage while empty.
- Ready path: in_ready depends only on count. No combinational path from out_ready to in_ready.
- Full queue:
  - in_ready=0, so a simultaneous pop cannot admit a new entry that cycle. Push resumes the cycle after the pop.
  - in_valid while full is ignored; fetch holds its data.
- Empty queue: an out_ready assertion is ignored and the pointers do not move.
- Flush:
  - On an edge with flush=1: pointers and count go to 0, so out_valid=0 and out_* show empty values in the next cycle.
  - Flush has priority over a simultaneous push and pop; both are dropped.
  - Stored data need not be cleared on flush.
  - Back-to-back flush cycles keep the queue empty.
- Ordering: strict FIFO, with no reordering and no duplication.
- DEPTH=1 is legal and gives a fully-registered stage with a one-cycle bubble between consecutive entries.

Test Plan:
1. Reset then single push: assert reset=0 for 2 cycles, release; push pc=0x100, instr=0x00500093, pred=0 -> next cycle out_valid=1, out_pc=0x100, out_instr=0x00500093, count=1; during reset out_instr=0x00000013, in_ready=1.
2. Back-pressure fill (DEPTH=2): out_ready=0; push pc=0x0, 0x4, 0x8 on consecutive cycles -> in_ready falls after the second push, third entry held by fetch, count=2. Raise out_ready -> heads pop in order 0x0, 0x4, then 0x8 is accepted the cycle after the first pop.
3. Streaming: in_valid=out_ready=1 for 10 cycles with pc 0x0..0x24 step 4 -> count stays at 1 after the first cycle; out_pc sequence matches the input sequence delayed by 1 cycle, with no gaps.
4. Zero substitution: push instr=0x00000000, pc=0x40, pred=1 -> out_instr=0x00000013, out_pc=0x40, out_pred_taken=1.
5. Flush collision: queue holds 2 entries; assert flush together with in_valid (pc=0x80) and out_ready -> next cycle count=0, out_valid=0, out_pc=0. The 0x80 entry never appears, and the next push emerges normally.
6. Async reset mid-stream: reset=0 asserted between clock edges while count=2 -> out_valid=0 and count=0 before the next rising edge; after release, the pointer wrap check (DEPTH=3, 7 pushes/pops) shows correct FIFO order.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID boundary queue: DEPTH-entry in-order FIFO between fetch and decode.
// Ports: clk, reset (async, active-low), flush, in_* (fetch side, valid/ready), out_* (decode side), count.
module if_id_queue #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 2,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_pred_taken,
  output logic [CW-1:0]   count
);

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic            pred_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic            push, pop, empty;
  logic [ILEN-1:0] wr_instr;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CW'(DEPTH));
  assign out_valid = !empty;
  assign count    = count_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // All-zero fetch words become the canonical NOP on the way in.
  assign wr_instr = (in_instr == '0) ? NOP_INSTR : in_instr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = nxt(wr_ptr_q);
      if (pop)  rd_ptr_d = nxt(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= NOP_INSTR;
        pc_q[i]    <= '0;
        pred_q[i]  <= 1'b0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= wr_instr;
      pc_q[wr_ptr_q]    <= in_pc;
      pred_q[wr_ptr_q]  <= in_pred_taken;
    end
  end

  // Empty queue never exposes stale storage.
  always_comb begin
    out_instr      = NOP_INSTR;
    out_pc         = '0;
    out_pred_taken = 1'b0;
    if (!empty) begin
      out_instr      = instr_q[rd_ptr_q];
      out_pc         = pc_q[rd_ptr_q];
      out_pred_taken = pred_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed testbench for if_id_queue (DEPTH=2 main instance, DEPTH=3 wrap instance).
// Table-driven vectors plus hand-written multi-cycle sequences.
module tb_if_id_queue;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        fl, iv, ir, ov, ordy, ipr, opr;
  logic [31:0] ipc, iins, opc, oins;
  logic [1:0]  cnt;

  logic        fl3, iv3, ir3, ov3, ordy3, ipr3, opr3;
  logic [31:0] ipc3, iins3, opc3, oins3;
  logic [1:0]  cnt3;

  if_id_queue #(.DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .flush(fl),
    .in_valid(iv), .in_ready(ir), .in_instr(iins),
    .in_pc(ipc), .in_pred_taken(ipr),
    .out_valid(ov), .out_ready(ordy), .out_instr(oins),
    .out_pc(opc), .out_pred_taken(opr), .count(cnt)
  );

  if_id_queue #(.DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .flush(fl3),
    .in_valid(iv3), .in_ready(ir3), .in_instr(iins3),
    .in_pc(ipc3), .in_pred_taken(ipr3),
    .out_valid(ov3), .out_ready(ordy3), .out_instr(oins3),
    .out_pc(opc3), .out_pred_taken(opr3), .count(cnt3)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        pr;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_pr;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t v [NV];

  localparam logic [31:0] NOP = 32'h00000013;

  task automatic drive(input logic f, input logic i, input logic [31:0] p,
                       input logic [31:0] n, input logic r, input logic o);
    fl = f; iv = i; ipc = p; iins = n; ipr = r; ordy = o;
  endtask

  initial begin
    logic [31:0] q [$];
    logic        psh, pp;

    // inputs | expected outputs seen in the same cycle (before the edge)
    v[0]  = '{0,1,32'h100,32'h00500093,0,0, 0,1,32'h0,  NOP,         0,2'd0};
    v[1]  = '{0,0,32'h0,  32'h0,       0,0, 1,1,32'h100,32'h00500093,0,2'd1};
    v[2]  = '{0,0,32'h0,  32'h0,       0,1, 1,1,32'h100,32'h00500093,0,2'd1};
    v[3]  = '{0,1,32'h0,  32'h00a00113,0,0, 0,1,32'h0,  NOP,         0,2'd0};
    v[4]  = '{0,1,32'h4,  32'h00b00193,0,0, 1,1,32'h0,  32'h00a00113,0,2'd1};
    v[5]  = '{0,1,32'h8,  32'h00c00213,0,0, 1,0,32'h0,  32'h00a00113,0,2'd2};
    v[6]  = '{0,1,32'h8,  32'h00c00213,0,0, 1,0,32'h0,  32'h00a00113,0,2'd2};
    v[7]  = '{0,1,32'h8,  32'h00c00213,0,1, 1,0,32'h0,  32'h00a00113,0,2'd2};
    v[8]  = '{0,1,32'h8,  32'h00c00213,0,1, 1,1,32'h4,  32'h00b00193,0,2'd1};
    v[9]  = '{0,0,32'h0,  32'h0,       0,1, 1,1,32'h8,  32'h00c00213,0,2'd1};
    v[10] = '{0,1,32'h40, 32'h0,       1,0, 0,1,32'h0,  NOP,         0,2'd0};
    v[11] = '{0,0,32'h0,  32'h0,       0,1, 1,1,32'h40, NOP,         1,2'd1};
    v[12] = '{0,1,32'h50, 32'h00d00293,0,0, 0,1,32'h0,  NOP,         0,2'd0};
    v[13] = '{0,1,32'h54, 32'h00e00313,1,0, 1,1,32'h50, 32'h00d00293,0,2'd1};
    v[14] = '{1,1,32'h80, 32'h00f00393,0,1, 1,0,32'h50, 32'h00d00293,0,2'd2};
    v[15] = '{0,1,32'h60, 32'h01000413,0,0, 0,1,32'h0,  NOP,         0,2'd0};
    v[16] = '{1,1,32'h84, 32'h01100493,0,1, 1,1,32'h60, 32'h01000413,0,2'd1};
    v[17] = '{1,1,32'h88, 32'h01100493,0,0, 0,1,32'h0,  NOP,         0,2'd0};
    v[18] = '{0,1,32'h90, 32'h01200513,1,0, 0,1,32'h0,  NOP,         0,2'd0};
    v[19] = '{0,0,32'h0,  32'h0,       0,1, 1,1,32'h90, 32'h01200513,1,2'd1};
    v[20] = '{0,0,32'h0,  32'h0,       0,1, 0,1,32'h0,  NOP,         0,2'd0};
    v[21] = '{0,0,32'h0,  32'h0,       0,0, 0,1,32'h0,  NOP,         0,2'd0};

    drive(0, 0, 0, 0, 0, 0);
    fl3 = 0; iv3 = 0; ipc3 = 0; iins3 = 0; ipr3 = 0; ordy3 = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov",    64'(ov),   64'(0));
    chk("rst_instr", 64'(oins), 64'(NOP));
    chk("rst_pc",    64'(opc),  64'(0));
    chk("rst_ir",    64'(ir),   64'(1));
    chk("rst_cnt",   64'(cnt),  64'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(v[i].fl, v[i].iv, v[i].pc, v[i].ins, v[i].pr, v[i].ordy);
      @(negedge clk);
      chk($sformatf("v%0d_ov", i),  64'(ov),   64'(v[i].e_ov));
      chk($sformatf("v%0d_ir", i),  64'(ir),   64'(v[i].e_ir));
      chk($sformatf("v%0d_pc", i),  64'(opc),  64'(v[i].e_pc));
      chk($sformatf("v%0d_ins", i), 64'(oins), 64'(v[i].e_ins));
      chk($sformatf("v%0d_pr", i),  64'(opr),  64'(v[i].e_pr));
      chk($sformatf("v%0d_cnt", i), 64'(cnt),  64'(v[i].e_cnt));
      @(posedge clk); #1;
    end

    // streaming: output is the input delayed by one cycle
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(0, 1, 32'(4 * i), 32'h00000093 | 32'(i << 20), 0, 1);
      else        drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      if (i == 0) begin
        chk("st0_ov",  64'(ov),  64'(0));
        chk("st0_cnt", 64'(cnt), 64'(0));
      end else begin
        chk($sformatf("st%0d_cnt", i), 64'(cnt), 64'(1));
        chk($sformatf("st%0d_pc", i),  64'(opc), 64'(4 * (i - 1)));
        chk($sformatf("st%0d_ins", i), 64'(oins),
            64'(32'h00000093 | 32'((i - 1) << 20)));
      end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("st_end_ov", 64'(ov), 64'(0));

    // async reset between edges with two entries held
    @(posedge clk); #1;
    drive(0, 1, 32'h300, 32'h00700713, 1, 0);
    @(posedge clk); #1;
    drive(0, 1, 32'h304, 32'h00800793, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("ar_pre_cnt", 64'(cnt), 64'(2));
    #2 reset = 1'b0;
    #1;
    chk("ar_ov",    64'(ov),   64'(0));
    chk("ar_cnt",   64'(cnt),  64'(0));
    chk("ar_pc",    64'(opc),  64'(0));
    chk("ar_instr", 64'(oins), 64'(NOP));
    chk("ar_pred",  64'(opr),  64'(0));
    chk("ar_ir",    64'(ir),   64'(1));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // DEPTH=3 pointer wrap: 7 entries through a 3-slot queue
    for (int i = 0; i < 10; i++) begin
      iv3   = (i < 7);
      ipc3  = 32'h200 + 32'(4 * i);
      iins3 = {ipc3[11:0], 20'h00093};
      ordy3 = (i >= 2);
      @(negedge clk);
      chk($sformatf("w%0d_cnt", i), 64'(cnt3), 64'(q.size()));
      chk($sformatf("w%0d_ov", i),  64'(ov3),  64'(q.size() != 0));
      if (q.size() != 0) begin
        chk($sformatf("w%0d_pc", i),  64'(opc3), 64'(q[0]));
        chk($sformatf("w%0d_ins", i), 64'(oins3),
            64'({q[0][11:0], 20'h00093}));
      end
      psh = iv3 && (q.size() < 3);
      pp  = ordy3 && (q.size() != 0);
      @(posedge clk); #1;
      if (pp)  void'(q.pop_front());
      if (psh) q.push_back(ipc3);
    end
    iv3 = 0; ordy3 = 0;
    @(negedge clk);
    chk("w_end_cnt", 64'(cnt3), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
